// File: rtl/instruction_fetch.sv
// instruction_fetch: RISC-V fetch stage with credit-limited imem requests
// and a PC-tagged FIFO toward decode; redirects flush buffered and in-flight words.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] SLOTS = (CW + 1)'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   ipc_q [DEPTH];
    logic [AW-1:0] ipc_wr_q, ipc_rd_q;
    logic [31:0]   fpc_q [DEPTH];
    logic [31:0]   finst_q [DEPTH];
    logic [AW-1:0] fwr_q, fwr_d, frd_q, frd_d;
    logic [CW-1:0] inflight_q, inflight_d, drop_q, drop_d, fcnt_q, fcnt_d;
    logic          req_fire, rsp_keep, id_fire;

    // Every response pops the in-flight PC queue, whether it is kept or dropped.
    always_comb begin
        imem_req_valid = rst_n && !redirect_valid && ({1'b0, inflight_q} + {1'b0, fcnt_q} < SLOTS);
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_keep       = imem_rsp_valid && !redirect_valid && drop_q == '0;
        id_valid       = fcnt_q != '0;
        id_fire        = id_valid && id_ready;
        pc_d           = redirect_valid ? {redirect_pc[31:2], 2'b00} : pc_q + (req_fire ? 32'd4 : 32'd0);
        inflight_d     = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_d         = redirect_valid ? inflight_q - CW'(imem_rsp_valid)
                                        : drop_q - CW'(imem_rsp_valid && drop_q != '0);
        fcnt_d         = redirect_valid ? '0 : fcnt_q + CW'(rsp_keep) - CW'(id_fire);
        fwr_d          = redirect_valid ? '0 : fwr_q + AW'(rsp_keep);
        frd_d          = redirect_valid ? '0 : frd_q + AW'(id_fire);
    end

    assign imem_req_addr = pc_q;
    assign id_inst       = finst_q[frd_q];
    assign id_pc         = fpc_q[frd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            ipc_wr_q   <= '0;
            ipc_rd_q   <= '0;
            fwr_q      <= '0;
            frd_q      <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            fcnt_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ipc_q[i]   <= '0;
                fpc_q[i]   <= '0;
                finst_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            fwr_q      <= fwr_d;
            frd_q      <= frd_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            fcnt_q     <= fcnt_d;
            if (req_fire) begin
                ipc_q[ipc_wr_q] <= pc_q;
                ipc_wr_q        <= ipc_wr_q + AW'(1);
            end
            if (imem_rsp_valid)
                ipc_rd_q <= ipc_rd_q + AW'(1);
            if (rsp_keep) begin
                fpc_q[fwr_q]   <= ipc_q[ipc_rd_q];
                finst_q[fwr_q] <= imem_rsp_data;
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and random checks of the fetch stage against an
// in-order instruction-stream model; a second instance covers PC wrap-around.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rdy, idr, redir;
    logic [31:0] redir_pc;
    logic        rv [2];
    logic [31:0] ra [2];
    logic        sv [2];
    logic [31:0] sd [2];
    logic        iv [2];
    logic [31:0] ii [2];
    logic [31:0] ip [2];

    int n_chk = 0, n_fail = 0;
    int nreq, nid, n1, lat0 = 1, now;
    logic [31:0] exp_req, exp_id, exp1, hold_pc, hold_inst;
    logic        hold_v;
    logic        s_rv, s_iv, s_sv;
    logic [31:0] s_ra, s_ip;
    logic [31:0] mq_a [2][$];
    int          mq_t [2][$];

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u0 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(rv[0]), .imem_req_ready(rdy), .imem_req_addr(ra[0]),
        .imem_rsp_valid(sv[0]), .imem_rsp_data(sd[0]),
        .redirect_valid(redir), .redirect_pc(redir_pc),
        .id_valid(iv[0]), .id_ready(idr), .id_inst(ii[0]), .id_pc(ip[0])
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u1 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(rv[1]), .imem_req_ready(1'b1), .imem_req_addr(ra[1]),
        .imem_rsp_valid(sv[1]), .imem_rsp_data(sd[1]),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .id_valid(iv[1]), .id_ready(1'b1), .id_inst(ii[1]), .id_pc(ip[1])
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // In-order memory; lat0 == 0 picks a random 1..3 cycle latency per request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now <= 0;
            for (int i = 0; i < 2; i++) begin
                mq_a[i].delete();
                mq_t[i].delete();
                sv[i] <= 1'b0;
                sd[i] <= '0;
            end
        end else begin
            now <= now + 1;
            for (int i = 0; i < 2; i++) begin
                if (rv[i] && (i == 1 || rdy)) begin
                    mq_a[i].push_back(ra[i]);
                    mq_t[i].push_back(now - 1 + ((i == 1) ? 1 : (lat0 != 0 ? lat0 : int'($urandom_range(3, 1)))));
                end
                if (mq_t[i].size() > 0 && mq_t[i][0] <= now) begin
                    sv[i] <= 1'b1;
                    sd[i] <= word(mq_a[i].pop_front());
                    void'(mq_t[i].pop_front());
                end else
                    sv[i] <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: sample at the falling edge, update the stream model, return after the next rising edge.
    task automatic cyc();
        @(negedge clk);
        s_rv = rv[0]; s_ra = ra[0]; s_iv = iv[0]; s_ip = ip[0]; s_sv = sv[0];
        if (rst_n) begin
            if (redir) chk("no_req_on_redirect", 32'(rv[0]), 0);
            if (rv[0]) chk("req_addr", ra[0], exp_req);
            if (rv[0] && rdy) begin exp_req += 4; nreq++; end
            if (hold_v) begin
                chk("hold_valid", 32'(iv[0]), 1);
                chk("hold_pc", ip[0], hold_pc);
                chk("hold_inst", ii[0], hold_inst);
            end
            hold_v = iv[0] && !idr && !redir; hold_pc = ip[0]; hold_inst = ii[0];
            if (iv[0] && idr) begin
                chk("id_pc", ip[0], exp_id);
                chk("id_inst", ii[0], word(exp_id));
                exp_id += 4; nid++;
            end
            if (redir) begin exp_req = {redir_pc[31:2], 2'b00}; exp_id = exp_req; end
            if (iv[1] && n1 < 6) begin
                chk("wrap_pc", ip[1], exp1);
                chk("wrap_inst", ii[1], word(exp1));
                exp1 += 4; n1++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rdy = 1'b1; idr = 1'b1; redir = 1'b0; redir_pc = '0; lat0 = 1;
        #1;
        chk("rst_req_valid", 32'(rv[0]), 0);
        chk("rst_id_valid", 32'(iv[0]), 0);
        chk("rst_req_addr", ra[0], 32'h0);
        chk("rst_id_inst", ii[0], 0);
        chk("rst_id_pc", ip[0], 0);
        chk("rst_req_addr_wrap", ra[1], 32'hFFFF_FFF8);
        chk("rst_id_valid_wrap", 32'(iv[1]), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        exp_req = 32'h0; exp_id = 32'h0; exp1 = 32'hFFFF_FFF8;
        n1 = 0; nreq = 0; nid = 0; hold_v = 1'b0;
    endtask

    initial begin
        #2;
        do_reset();
        cyc(); chk("t1_req0_valid", 32'(s_rv), 1); chk("t1_req0_addr", s_ra, 0); chk("t1_idv_c0", 32'(s_iv), 0);
        cyc(); chk("t1_idv_c1", 32'(s_iv), 0); chk("t1_req1_addr", s_ra, 4);
        cyc(); chk("t1_idv_c2", 32'(s_iv), 1); chk("t1_idpc_c2", s_ip, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(); chk("t1_stream_valid", 32'(s_iv), 1); chk("t1_stream_req", 32'(s_rv), 1);
        end
        chk("t5_wrap_count", 32'(n1), 6);

        do_reset();
        idr = 1'b0;
        repeat (10) cyc();
        chk("t2_req_count", 32'(nreq), 4);
        chk("t2_head_pc", s_ip, 0);
        idr = 1'b1;
        repeat (8) cyc();
        chk("t2_drained", 32'(nid >= 4), 1);

        do_reset();
        lat0 = 3;
        cyc(); cyc();
        redir = 1'b1; redir_pc = 32'h0000_0102;
        cyc(); chk("t3_no_req", 32'(s_rv), 0);
        redir = 1'b0;
        cyc(); chk("t3_req_valid", 32'(s_rv), 1); chk("t3_req_addr", s_ra, 32'h100);
        nid = 0;
        for (int i = 0; i < 20 && nid == 0; i++) cyc();
        chk("t3_got_id", 32'(nid > 0), 1);

        do_reset();
        repeat (6) cyc();
        redir = 1'b1; redir_pc = 32'h0000_0200;
        cyc(); chk("t4_rsp_pre", 32'(s_sv), 1); chk("t4_id_pre", 32'(s_iv), 1);
        redir = 1'b0;
        cyc(); chk("t4_fifo_empty", 32'(s_iv), 0); chk("t4_req_addr", s_ra, 32'h200);
        cyc(); chk("t4_idv_t2", 32'(s_iv), 0);
        cyc(); chk("t4_idv_t3", 32'(s_iv), 1); chk("t4_idpc_t3", s_ip, 32'h200);

        do_reset();
        idr = 1'b0;
        repeat (8) cyc();
        chk("t6_full_valid", 32'(s_iv), 1);
        do_reset();
        repeat (6) cyc();
        chk("t6_restart", 32'(nid > 0), 1);

        do_reset();
        lat0 = 0;
        for (int i = 0; i < 400; i++) begin
            rdy      = $urandom_range(0, 3) != 0;
            idr      = $urandom_range(0, 3) != 0;
            redir    = $urandom_range(0, 19) == 0;
            redir_pc = $urandom;
            cyc();
        end
        redir = 1'b0; rdy = 1'b1; idr = 1'b1;
        repeat (20) cyc();
        chk("rand_progress", 32'(nid > 20), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
